// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART command-frame parser.
package uart_frame_pkg;

   localparam logic [7:0] HDR0 = 8'hA5;
   localparam logic [7:0] HDR1 = 8'h5A;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_LEN_W   = 4;

   typedef enum logic [2:0] {
      S_HDR0 = 3'd0,
      S_HDR1 = 3'd1,
      S_CMD  = 3'd2,
      S_LEN  = 3'd3,
      S_PAY  = 3'd4,
      S_CHK  = 3'd5,
      S_OUT  = 3'd6
   } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout counter for the frame parser.
// Instantiated only when UART_FRAME_TIMEOUT_EN is defined.
// expire is asserted on the cycle in which the count sits at TIMEOUT_CYC-1
// and no clear is requested, so a coincident byte accept always wins.
module uart_frame_timeout #(
   parameter int TIMEOUT_CYC = 10416*4
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYC);

   logic [CW-1:0] r_cnt;

   assign expire = en & ~clr & (r_cnt == CW'(TIMEOUT_CYC - 1));

   // Count idle cycles; restart on clear or after an expiry.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr || expire) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_frame_parser.sv
// Command-frame parser sitting behind the UART byte receiver.
// Frame: A5 5A CMD LEN PAYLOAD[LEN] CHK, CHK = XOR of CMD, LEN and payload.
// A verified frame is held on frame_* until frame_ready; malformed frames
// produce single-cycle err_* pulses.
// Optional feature: define UART_FRAME_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYC idle cycles (err_timeout pulse); otherwise err_timeout is 0.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_LEN     = DEF_MAX_LEN,
   parameter int LEN_W       = DEF_LEN_W,
   parameter int TIMEOUT_CYC = 10416*4
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_ready,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [7:0]            frame_cmd,
   output logic [LEN_W-1:0]      frame_len,
   output logic [MAX_LEN*8-1:0]  frame_payload,
   output logic                  err_chk,
   output logic                  err_len,
   output logic                  err_timeout
);

   state_t               r_state;
   state_t               w_nxt;
   logic [7:0]           r_cmd;
   logic [LEN_W-1:0]     r_len;
   logic [MAX_LEN*8-1:0] r_payload;
   logic [7:0]           r_chk;
   logic [LEN_W-1:0]     r_idx;
   logic                 r_err_chk;
   logic                 r_err_len;

   logic                 w_accept;
   logic [7:0]           w_byte;
   logic                 w_ld_cmd;
   logic                 w_ld_len;
   logic                 w_ld_pay;
   logic                 w_err_chk;
   logic                 w_err_len;
   logic                 w_expire;

   // Readiness depends only on the state so upstream never sees a loop.
   assign rx_ready      = (r_state != S_OUT);
   assign w_accept      = rx_valid & rx_ready;
   assign w_byte        = rx_data[7:0];

   assign frame_valid   = (r_state == S_OUT);
   assign frame_cmd     = r_cmd;
   assign frame_len     = r_len;
   assign frame_payload = r_payload;
   assign err_chk       = r_err_chk;
   assign err_len       = r_err_len;

`ifdef UART_FRAME_TIMEOUT_EN
   logic w_to_clr;
   logic r_err_to;

   // Idle time only matters while a frame is partially received.
   assign w_to_clr = w_accept | (r_state == S_HDR0) | (r_state == S_OUT);

   uart_frame_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .clr     (w_to_clr),
      .en      (~w_to_clr),
      .expire  (w_expire)
   );

   // Register the expiry into a one-cycle pulse.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_to <= 1'b0;
      end else begin
         r_err_to <= w_expire;
      end
   end

   assign err_timeout = r_err_to;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYC == 0);
   assign w_expire         = 1'b0;
   assign err_timeout      = 1'b0;
`endif

   // State register.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HDR0;
      end else begin
         r_state <= w_nxt;
      end
   end

   // Next-state decode and datapath load strobes.
   always_comb begin
      w_nxt     = r_state;
      w_ld_cmd  = 1'b0;
      w_ld_len  = 1'b0;
      w_ld_pay  = 1'b0;
      w_err_chk = 1'b0;
      w_err_len = 1'b0;
      case (r_state)
         S_HDR0: begin
            if (w_accept && (w_byte == HDR0)) w_nxt = S_HDR1;
         end
         S_HDR1: begin
            if (w_accept) begin
               if (w_byte == HDR1)      w_nxt = S_CMD;
               else if (w_byte == HDR0) w_nxt = S_HDR1;
               else                     w_nxt = S_HDR0;
            end
         end
         S_CMD: begin
            if (w_accept) begin
               w_ld_cmd = 1'b1;
               w_nxt    = S_LEN;
            end
         end
         S_LEN: begin
            if (w_accept) begin
               if (w_byte > 8'(MAX_LEN)) begin
                  w_err_len = 1'b1;
                  w_nxt     = S_HDR0;
               end else begin
                  w_ld_len = 1'b1;
                  w_nxt    = (w_byte == 8'd0) ? S_CHK : S_PAY;
               end
            end
         end
         S_PAY: begin
            if (w_accept) begin
               w_ld_pay = 1'b1;
               if (r_idx == (r_len - LEN_W'(1))) w_nxt = S_CHK;
            end
         end
         S_CHK: begin
            if (w_accept) begin
               if (w_byte == r_chk) begin
                  w_nxt = S_OUT;
               end else begin
                  w_err_chk = 1'b1;
                  w_nxt     = S_HDR0;
               end
            end
         end
         S_OUT: begin
            if (frame_ready) w_nxt = S_HDR0;
         end
         default: w_nxt = S_HDR0;
      endcase
      // Expiry never coincides with an accept, so no load strobe is lost.
      if (w_expire) w_nxt = S_HDR0;
   end

   // Frame fields, running checksum, payload index and error pulses.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd     <= '0;
         r_len     <= '0;
         r_payload <= '0;
         r_chk     <= '0;
         r_idx     <= '0;
         r_err_chk <= 1'b0;
         r_err_len <= 1'b0;
      end else begin
         r_err_chk <= w_err_chk;
         r_err_len <= w_err_len;
         if (w_ld_cmd) begin
            r_cmd     <= w_byte;
            r_chk     <= w_byte;
            r_payload <= '0;
         end
         if (w_ld_len) begin
            r_len <= w_byte[LEN_W-1:0];
            r_chk <= r_chk ^ w_byte;
            r_idx <= '0;
         end
         if (w_ld_pay) begin
            r_payload[{r_idx, 3'b000} +: 8] <= w_byte;
            r_chk <= r_chk ^ w_byte;
            r_idx <= r_idx + LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: valid, zero-length, bad checksum,
// oversize length, noise/re-sync, reset mid-frame and inter-byte timeout.
module tb_uart_frame_parser;

   logic        sys_clk;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        frame_valid;
   logic        frame_ready;
   logic [7:0]  frame_cmd;
   logic [3:0]  frame_len;
   logic [63:0] frame_payload;
   logic        err_chk;
   logic        err_len;
   logic        err_timeout;

   int errors = 0;
   int checks = 0;

   uart_frame_parser #(
      .DATA_WIDTH  (8),
      .MAX_LEN     (8),
      .LEN_W       (4),
      .TIMEOUT_CYC (100)
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .frame_cmd     (frame_cmd),
      .frame_len     (frame_len),
      .frame_payload (frame_payload),
      .err_chk       (err_chk),
      .err_len       (err_len),
      .err_timeout   (err_timeout)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Present one byte at a negedge; it is accepted on the next posedge and the
   // task returns on the following negedge with rx_valid dropped.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!rx_ready && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL send_ready: rx_ready=%b required 1 within 100 cycles", rx_ready);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge sys_clk);
      rx_valid = 1'b0;
   endtask

   // Complete the output handshake for one cycle.
   task automatic ack_frame();
      frame_ready = 1'b1;
      @(negedge sys_clk);
      frame_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b need 1", rx_ready); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b need 0", frame_valid); end
      checks++; if (frame_cmd !== 8'h00 || frame_len !== 4'h0) begin errors++; $display("FAIL reset_cmd_len: got %h/%h need 00/0", frame_cmd, frame_len); end
      checks++; if (frame_payload !== 64'h0) begin errors++; $display("FAIL reset_payload: got %h need 0", frame_payload); end
      checks++; if ({err_chk, err_len, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b need 000", {err_chk, err_len, err_timeout}); end
      rst_n = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic test_valid_frame();
      logic [7:0] seq [7] = '{8'hA5, 8'h5A, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
      foreach (seq[i]) send_byte(seq[i]);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL valid_early: frame_valid=%b need 0 before checksum", frame_valid); end
      send_byte(8'h13);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL valid_latency: frame_valid=%b need 1", frame_valid); end
      checks++; if (frame_cmd !== 8'h10 || frame_len !== 4'd3) begin errors++; $display("FAIL valid_cmd_len: got %h/%0d need 10/3", frame_cmd, frame_len); end
      checks++; if (frame_payload !== 64'h0000_0000_0033_2211) begin errors++; $display("FAIL valid_payload: got %h need 0000000000332211", frame_payload); end
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL valid_rx_ready: got %b need 0", rx_ready); end
      ack_frame();
      checks++; if (frame_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL valid_release: valid/ready=%b%b need 01", frame_valid, rx_ready); end
   endtask

   task automatic test_zero_len_hold();
      int bad = 0;
      logic [7:0] seq [5] = '{8'hA5, 8'h5A, 8'h20, 8'h00, 8'h20};
      foreach (seq[i]) send_byte(seq[i]);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h20 || frame_len !== 4'd0) begin errors++; $display("FAIL zero_frame: valid/cmd/len=%b/%h/%0d need 1/20/0", frame_valid, frame_cmd, frame_len); end
      checks++; if (frame_payload !== 64'h0) begin errors++; $display("FAIL zero_payload: got %h need 0", frame_payload); end
      // Offer junk bytes while the frame is held; none may be taken.
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      for (int c = 0; c < 50; c++) begin
         @(negedge sys_clk);
         if (frame_valid !== 1'b1 || rx_ready !== 1'b0 || frame_cmd !== 8'h20 ||
             frame_len !== 4'd0 || frame_payload !== 64'h0) bad++;
      end
      rx_valid = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL zero_hold: %0d unstable cycles of 50, need 0", bad); end
      ack_frame();
      checks++; if (frame_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL zero_release: valid/ready=%b%b need 01", frame_valid, rx_ready); end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] seq [5] = '{8'hA5, 8'h5A, 8'h10, 8'h01, 8'hAA};
      logic [7:0] good [6] = '{8'hA5, 8'h5A, 8'h30, 8'h02, 8'h01, 8'h02};
      foreach (seq[i]) send_byte(seq[i]);
      send_byte(8'hBA);
      checks++; if (err_chk !== 1'b1 || err_len !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL chk_pulse: chk/len/to=%b%b%b need 100", err_chk, err_len, err_timeout); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL chk_novalid: frame_valid=%b need 0", frame_valid); end
      @(negedge sys_clk);
      checks++; if (err_chk !== 1'b0) begin errors++; $display("FAIL chk_width: err_chk=%b need 0 on second cycle", err_chk); end
      foreach (good[i]) send_byte(good[i]);
      send_byte(8'h31);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h30 || frame_len !== 4'd2) begin errors++; $display("FAIL chk_next: valid/cmd/len=%b/%h/%0d need 1/30/2", frame_valid, frame_cmd, frame_len); end
      checks++; if (frame_payload !== 64'h0000_0000_0000_0201) begin errors++; $display("FAIL chk_next_payload: got %h need 0000000000000201", frame_payload); end
      ack_frame();
   endtask

   task automatic test_oversize_len();
      logic [7:0] seq [4] = '{8'hA5, 8'h5A, 8'h01, 8'h10};
      logic [7:0] rsync [5] = '{8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h00};
      foreach (seq[i]) send_byte(seq[i]);
      checks++; if (err_len !== 1'b1 || err_chk !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL len_pulse: chk/len/to=%b%b%b need 010", err_chk, err_len, err_timeout); end
      @(negedge sys_clk);
      checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL len_width: err_len=%b need 0 on second cycle", err_len); end
      foreach (rsync[i]) send_byte(rsync[i]);
      send_byte(8'h01);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h01 || frame_len !== 4'd0) begin errors++; $display("FAIL len_resync: valid/cmd/len=%b/%h/%0d need 1/01/0", frame_valid, frame_cmd, frame_len); end
      ack_frame();
   endtask

   task automatic test_noise_and_reset();
      logic [7:0] noise [4] = '{8'h00, 8'hFF, 8'hA5, 8'h13};
      logic [7:0] f1 [6] = '{8'hA5, 8'h5A, 8'h42, 8'h01, 8'h7E, 8'h3D};
      logic [7:0] part [6] = '{8'hA5, 8'h5A, 8'h55, 8'h04, 8'h01, 8'h02};
      logic [7:0] tail [3] = '{8'h03, 8'h04, 8'h57};
      logic [7:0] f2 [6] = '{8'hA5, 8'h5A, 8'h66, 8'h01, 8'h99, 8'hFE};
      foreach (noise[i]) send_byte(noise[i]);
      checks++; if (frame_valid !== 1'b0 || {err_chk, err_len} !== 2'b00) begin errors++; $display("FAIL noise_quiet: valid/chk/len=%b%b%b need 000", frame_valid, err_chk, err_len); end
      foreach (f1[i]) send_byte(f1[i]);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h42 || frame_payload !== 64'h7E) begin errors++; $display("FAIL noise_frame: valid/cmd/payload=%b/%h/%h need 1/42/7e", frame_valid, frame_cmd, frame_payload); end
      ack_frame();
      foreach (part[i]) send_byte(part[i]);
      rst_n = 1'b0;
      #1;
      checks++; if (frame_cmd !== 8'h00 || frame_len !== 4'd0 || frame_payload !== 64'h0) begin errors++; $display("FAIL rst_mid_fields: cmd/len/payload=%h/%0d/%h need 00/0/0", frame_cmd, frame_len, frame_payload); end
      checks++; if (frame_valid !== 1'b0 || rx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: valid/ready=%b%b need 01", frame_valid, rx_ready); end
      @(negedge sys_clk);
      rst_n = 1'b1;
      @(negedge sys_clk);
      foreach (tail[i]) send_byte(tail[i]);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: frame_valid=%b need 0", frame_valid); end
      foreach (f2[i]) send_byte(f2[i]);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h66 || frame_payload !== 64'h99) begin errors++; $display("FAIL rst_after: valid/cmd/payload=%b/%h/%h need 1/66/99", frame_valid, frame_cmd, frame_payload); end
      ack_frame();
   endtask

   task automatic test_timeout();
      int pulses = 0;
      logic [7:0] head [3] = '{8'hA5, 8'h5A, 8'h10};
      foreach (head[i]) send_byte(head[i]);
      for (int c = 0; c < 110; c++) begin
         @(negedge sys_clk);
         if (err_timeout === 1'b1) pulses++;
      end
`ifdef UART_FRAME_TIMEOUT_EN
      checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulse: %0d pulses need 1", pulses); end
      foreach (head[i]) send_byte(head[i]);
`else
      checks++; if (pulses != 0) begin errors++; $display("FAIL timeout_absent: %0d pulses need 0", pulses); end
`endif
      send_byte(8'h01);
      send_byte(8'h22);
      send_byte(8'h33);
      checks++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 4'd1 || frame_payload !== 64'h22) begin errors++; $display("FAIL timeout_frame: valid/cmd/len/payload=%b/%h/%0d/%h need 1/10/1/22", frame_valid, frame_cmd, frame_len, frame_payload); end
      ack_frame();
   endtask

   initial begin
      rst_n       = 1'b0;
      rx_valid    = 1'b0;
      rx_data     = 8'h00;
      frame_ready = 1'b0;
      test_reset();
      test_valid_frame();
      test_zero_len_hold();
      test_bad_checksum();
      test_oversize_len();
      test_noise_and_reset();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes its byte stream over the rx valid/ready handshake and delineates framed commands: header 0xA5 0x5A, CMD, LEN, LEN payload bytes, then an XOR checksum.
- Presents each verified frame (cmd, len, payload) on a held valid/ready output to the DPSK control logic.
- Flags malformed frames with error pulses.

Parameters:
- DATA_WIDTH, 8, byte width; must equal the UART data width.
- MAX_LEN, 8, maximum payload bytes per frame (1..15).
- LEN_W, 4, width of the frame_len output; holds 0..MAX_LEN.
- TIMEOUT_CYC, 10416*4, inter-byte timeout in sys_clk cycles; used only with the timeout feature.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  byte available from the UART receiver.
- rx_data  in  DATA_WIDTH  received byte.
- rx_ready  out  1  parser accepts a byte this cycle.
- frame_valid  out  1  verified frame held on the outputs.
- frame_ready  in  1  consumer accepts the frame.
- frame_cmd  out  8  command byte.
- frame_len  out  LEN_W  payload length.
- frame_payload  out  MAX_LEN*8  payload; byte k is at bits [8k+7:8k]; unused bytes are 0.
- err_chk  out  1  one-cycle pulse on checksum mismatch.
- err_len  out  1  one-cycle pulse when LEN > MAX_LEN.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout; constant 0 when the feature is absent.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to S_HDR0.
  - frame_valid, err_* = 0.
  - frame_cmd, frame_len, frame_payload = 0.
  - Running checksum and payload index = 0.
  - rx_ready = 1.
- Reset mid-frame discards the partial frame.
- Byte accept: rx_valid & rx_ready on a rising sys_clk edge. State advances only on an accept, except S_OUT and timeout.
- rx_ready = 1 in every state except S_OUT. rx_ready is combinational from the state only, never from rx_valid.
- S_HDR0: byte==0xA5 → S_HDR1; any other byte → stay.
- S_HDR1:
  - 0x5A → S_CMD.
  - 0xA5 → stay in S_HDR1 (re-sync).
  - Other → S_HDR0.
- S_CMD: frame_cmd ← byte; chk ← byte; frame_payload cleared to 0 → S_LEN.
- S_LEN:
  - byte > MAX_LEN → err_len pulse next cycle, → S_HDR0.
  - byte == 0 → frame_len ← 0, chk ^= byte → S_CHK.
  - Else → frame_len ← byte, chk ^= byte, idx ← 0 → S_PAY.
- S_PAY: payload byte[idx] ← byte; chk ^= byte; idx++. When idx == frame_len-1 on accept → S_CHK.
- S_CHK:
  - byte == chk → S_OUT, frame_valid=1 on the cycle after the accept (latency 1 cycle from the checksum byte).
  - Mismatch → err_chk pulse, → S_HDR0.
- S_OUT:
  - frame_valid held.
  - frame_cmd, frame_len, frame_payload stable until the handshake.
  - frame_valid & frame_ready → frame_valid=0, → S_HDR0 on the next cycle (rx_ready=1 again).
- Bytes arriving while in S_OUT are not accepted. The upstream receiver owns loss of those bytes.
- Checksum: 8-bit XOR over CMD, LEN and all payload bytes; no carry.
- Error pulses are exactly 1 cycle and mutually exclusive.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined:
  - Counter width is $clog2(TIMEOUT_CYC).
  - Cleared on every accepted byte and whenever in S_HDR0 or S_OUT; increments otherwise.
  - Reaching TIMEOUT_CYC-1 → err_timeout pulse, → S_HDR0, partial frame discarded.
  - If a byte accept coincides with expiry, the byte wins and the counter clears.
- Undefined: no counter logic; err_timeout tied 0; the parser waits indefinitely mid-frame.

Decomposition:
- Package uart_frame_pkg:
  - HDR0=8'hA5, HDR1=8'h5A.
  - State enum (S_HDR0, S_HDR1, S_CMD, S_LEN, S_PAY, S_CHK, S_OUT).
  - Default MAX_LEN and LEN_W constants.
- One sub-module, uart_frame_timeout:
  - Counter with clr/en/expire ports.
  - Instantiated only under UART_FRAME_TIMEOUT_EN.

Test Plan:
- Valid frame: A5 5A 10 03 11 22 33, chk=10^03^11^22^33=13 → frame_valid 1 cycle after chk accept; cmd=0x10, len=3, payload[23:0]=0x332211, upper bytes 0.
- Zero length: A5 5A 20 00 20 → frame_valid, cmd=0x20, len=0, payload all 0; hold frame_ready=0 for 50 cycles → outputs stable, rx_ready=0; then frame_ready=1 → frame_valid=0 next cycle, rx_ready=1.
- Bad checksum: A5 5A 10 01 AA BA (expected 0xBB) → err_chk single pulse, no frame_valid; following valid frame is parsed correctly.
- Oversize length: A5 5A 01 10 (16 > MAX_LEN=8) → err_len pulse, return to S_HDR0; re-sync: A5 A5 5A 01 00 01 → frame accepted.
- Noise and reset: 00 FF A5 13 then a valid frame → only that frame is reported; assert rst_n=0 mid-payload → all outputs 0 immediately, state S_HDR0.
- Timeout (UART_FRAME_TIMEOUT_EN, TIMEOUT_CYC=100): A5 5A 10, then idle 100 cycles → err_timeout pulse; next valid frame is parsed; without the macro, err_timeout stays 0 and the frame completes when bytes resume.
